// File: rtl/imem_if.sv
// Instruction-memory link: valid/ready request channel plus a single-cycle response strobe.
interface imem_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic        resp_valid;
   logic [31:0] resp_data;

   modport master (output req_valid, addr, input req_ready, resp_valid, resp_data);
   modport slave  (input req_valid, addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_unit.sv
// IF stage and IF/ID register: one outstanding fetch, redirect-aware drop of stale responses,
// and a one-entry hold buffer for responses that land while the pipeline is stalled.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall_if,
   input  logic        stall_id,
   input  logic        flush_id,
   input  logic [1:0]  pc_sel_ex,
   input  logic [31:0] pc_target_ex,
   imem_if.master      imem,
   output logic        valid_id,
   output logic [31:0] inst_id,
   output logic [31:0] pc_id,
   output logic [31:0] pc_add4_id
);
   typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_if, pc_nxt;
   logic        drop, drop_nxt;
   logic [31:0] buf_data, buf_nxt;
   logic        deliver;
   logic [31:0] deliver_data;
   logic        redirect, accept;
   logic [31:0] pc_tgt;

   assign redirect = (pc_sel_ex != 2'd0);
   assign accept   = !stall_if && !stall_id && !flush_id;
   assign pc_tgt   = pc_target_ex & ~32'h3;
   assign imem.addr = pc_if;

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc_if;
      drop_nxt       = drop;
      buf_nxt        = buf_data;
      deliver        = 1'b0;
      deliver_data   = imem.resp_data;
      imem.req_valid = 1'b0;
      case (state)
         REQ: begin
            imem.req_valid = rstn;
            if (redirect) pc_nxt = pc_tgt;
            if (rstn && imem.req_ready) begin
               state_nxt = WAIT;
               // The accepted address is already stale; its response must be thrown away.
               if (redirect) drop_nxt = 1'b1;
            end
         end
         WAIT: begin
            if (imem.resp_valid) begin
               if (drop || redirect) begin
                  drop_nxt  = 1'b0;
                  if (redirect) pc_nxt = pc_tgt;
                  state_nxt = REQ;
               end else if (accept) begin
                  deliver   = 1'b1;
                  pc_nxt    = pc_if + 32'd4;
                  state_nxt = REQ;
               end else begin
                  buf_nxt   = imem.resp_data;
                  state_nxt = HOLD;
               end
            end else if (redirect) begin
               pc_nxt   = pc_tgt;
               drop_nxt = 1'b1;
            end
         end
         HOLD: begin
            // pc_if is frozen in HOLD, so it doubles as the buffered instruction's PC.
            deliver_data = buf_data;
            if (redirect) begin
               pc_nxt    = pc_tgt;
               state_nxt = REQ;
            end else if (accept) begin
               deliver   = 1'b1;
               pc_nxt    = pc_if + 32'd4;
               state_nxt = REQ;
            end
         end
         default: state_nxt = REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= REQ;
         pc_if    <= RESET_PC;
         drop     <= 1'b0;
         buf_data <= NOP_INST;
         valid_id <= 1'b0;
         inst_id  <= NOP_INST;
         pc_id    <= 32'd0;
      end else begin
         state    <= state_nxt;
         pc_if    <= pc_nxt;
         drop     <= drop_nxt;
         buf_data <= buf_nxt;
         if (flush_id) begin
            valid_id <= 1'b0;
            inst_id  <= NOP_INST;
            pc_id    <= pc_if;
         end else if (!stall_id) begin
            valid_id <= deliver;
            inst_id  <= deliver ? deliver_data : NOP_INST;
            pc_id    <= pc_if;
         end
      end
   end

   assign pc_add4_id = pc_id + 32'd4;
endmodule
